// File: rtl/cat_led_pkg.sv
// Shared command codes and FSM state type for the cat/LED controller.
package cat_led_pkg;

   localparam logic [7:0] CMD_CLR_BASE = 8'h41;
   localparam logic [7:0] CMD_SET_BASE = 8'h61;
   localparam logic [7:0] CMD_ALL_UP   = 8'h60;
   localparam logic [7:0] CMD_ALL_DOWN = 8'h7E;
   localparam logic [7:0] CMD_BLINK    = 8'h21;
   localparam logic [7:0] CMD_DUTY     = 8'h23;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_DUTY = 1'b1
   } state_t;

endpackage

// File: rtl/cat_led_ctrl_pwm_gen.sv
// Free-running PWM counter with duty compare; all-ones duty means always on.
module pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PWM_BITS-1:0] duty,
   output logic                pwm_on
);

   logic [PWM_BITS-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt + 1'b1;
   end

   assign pwm_on = (cnt < duty) || (duty == '1);

endmodule

// File: rtl/cat_led_ctrl.sv
// UART-command driven cat target controller: per-channel up/down state,
// global PWM-dimmed overlay, blink of shot cats and a duty-setting command.
//
// state     | meaning
// IDLE      | decode each received byte as a command
// WAIT_DUTY | next received byte is the duty operand; times out to IDLE
module cat_led_ctrl
   import cat_led_pkg::*;
#(
   parameter int          CHANNELS       = 8,
   parameter int          PWM_BITS       = 8,
   parameter int unsigned DEFAULT_DUTY   = 2**(PWM_BITS-1),
   parameter int          TIMEOUT_CYCLES = 1_000_000,
   parameter int          BLINK_DIV      = 50_000_000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   input  logic [CHANNELS-1:0] overlay,
   input  logic                overlay_en,
   output logic [CHANNELS-1:0] led,
   output logic [CHANNELS-1:0] cat_status,
   output logic [PWM_BITS-1:0] duty,
   output logic                cmd_ack,
   output logic                cmd_err
);

   localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   state_t               state, state_nxt;
   logic [CHANNELS-1:0]  cat_nxt, clr_mask, set_mask, led_nxt;
   logic [PWM_BITS-1:0]  duty_nxt, duty_operand;
   logic [TMO_W-1:0]     tcnt, tcnt_nxt;
   logic [BLINK_W-1:0]   bcnt;
   logic                 blink_en, blink_en_nxt, blink_phase;
   logic                 ack_nxt, err_nxt, pwm_on;

   pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
      .clk     (clk),
      .reset_n (reset_n),
      .duty    (duty),
      .pwm_on  (pwm_on)
   );

   // Narrow duty takes the low bits; wide duty left-aligns the byte.
   if (PWM_BITS <= 8) begin : g_duty_narrow
      assign duty_operand = rx_data[PWM_BITS-1:0];
   end else begin : g_duty_wide
      assign duty_operand = {rx_data, {(PWM_BITS-8){1'b0}}};
   end

   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         clr_mask[i] = (rx_data == CMD_CLR_BASE + 8'(i));
         set_mask[i] = (rx_data == CMD_SET_BASE + 8'(i));
      end
   end

   always_comb begin
      state_nxt    = state;
      cat_nxt      = cat_status;
      duty_nxt     = duty;
      blink_en_nxt = blink_en;
      tcnt_nxt     = tcnt;
      ack_nxt      = 1'b0;
      err_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               if (|clr_mask) begin
                  cat_nxt = cat_status & ~clr_mask;
                  ack_nxt = 1'b1;
               end else if (|set_mask) begin
                  cat_nxt = cat_status | set_mask;
                  ack_nxt = 1'b1;
               end else if (rx_data == CMD_ALL_UP) begin
                  cat_nxt = '1;
                  ack_nxt = 1'b1;
               end else if (rx_data == CMD_ALL_DOWN) begin
                  cat_nxt = '0;
                  ack_nxt = 1'b1;
               end else if (rx_data == CMD_BLINK) begin
                  blink_en_nxt = ~blink_en;
                  ack_nxt      = 1'b1;
               end else if (rx_data == CMD_DUTY) begin
                  state_nxt = WAIT_DUTY;
                  tcnt_nxt  = '0;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         WAIT_DUTY: begin
            if (rx_valid) begin
               duty_nxt  = duty_operand;
               ack_nxt   = 1'b1;
               state_nxt = IDLE;
               tcnt_nxt  = '0;
            end else if (tcnt == TMO_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
               tcnt_nxt  = '0;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      led_nxt = (overlay & {CHANNELS{overlay_en & pwm_on}})
              | (~cat_status & {CHANNELS{blink_en ? blink_phase : 1'b1}});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cat_status <= '1;
         duty       <= PWM_BITS'(DEFAULT_DUTY);
         blink_en   <= 1'b0;
         tcnt       <= '0;
         cmd_ack    <= 1'b0;
         cmd_err    <= 1'b0;
         led        <= '0;
      end else begin
         state      <= state_nxt;
         cat_status <= cat_nxt;
         duty       <= duty_nxt;
         blink_en   <= blink_en_nxt;
         tcnt       <= tcnt_nxt;
         cmd_ack    <= ack_nxt;
         cmd_err    <= err_nxt;
         led        <= led_nxt;
      end
   end

   // Blink timebase runs continuously so enabling blink is phase-coherent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bcnt        <= '0;
         blink_phase <= 1'b0;
      end else if (bcnt == BLINK_LAST) begin
         bcnt        <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         bcnt <= bcnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cat_led_ctrl.sv
// Directed bench for cat_led_ctrl: an 8-channel and a 4-channel instance share stimulus.
module tb_cat_led_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] overlay = '0;
   logic       overlay_en = 1'b0;

   logic [7:0] led8, cat8, duty8, duty4;
   logic [3:0] led4, cat4;
   logic       ack8, err8, ack4, err4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cat_led_ctrl #(
      .CHANNELS(8), .PWM_BITS(8), .TIMEOUT_CYCLES(100), .BLINK_DIV(10)
   ) dut8 (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .overlay(overlay), .overlay_en(overlay_en), .led(led8),
      .cat_status(cat8), .duty(duty8), .cmd_ack(ack8), .cmd_err(err8)
   );

   cat_led_ctrl #(
      .CHANNELS(4), .TIMEOUT_CYCLES(100), .BLINK_DIV(10)
   ) dut4 (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .overlay(overlay[3:0]), .overlay_en(overlay_en), .led(led4),
      .cat_status(cat4), .duty(duty4), .cmd_ack(ack4), .cmd_err(err4)
   );

   typedef struct {
      logic [7:0] b;
      logic [7:0] cat8;
      logic       ack8;
      logic       err8;
      logic [3:0] cat4;
      logic       ack4;
      logic       err4;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic count_full(input int cycles, output int n8, output int n4);
      n8 = 0;
      n4 = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if (led8 == 8'hFF) n8++;
         if (led4 == 4'hF) n4++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " led8"}, led8, 8'h00);
      check({tag, " led4"}, led4, 4'h0);
      check({tag, " cat8"}, cat8, 8'hFF);
      check({tag, " cat4"}, cat4, 4'hF);
      check({tag, " duty8"}, duty8, 8'h80);
      check({tag, " duty4"}, duty4, 8'h80);
      check({tag, " ack/err"}, {ack8, err8, ack4, err4}, 4'b0000);
   endtask

   task automatic no_pulses(input string name, input int cycles);
      int pulses;
      pulses = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if (ack8 | err8 | ack4 | err4) pulses++;
      end
      check(name, pulses, 0);
   endtask

   initial begin
      int n8, n4, found, prev, last_t, ntog, bad_gap;

      vecs[0]  = '{8'h43, 8'hFB, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0};
      vecs[1]  = '{8'h63, 8'hFF, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
      vecs[2]  = '{8'h45, 8'hEF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1};
      vecs[3]  = '{8'h66, 8'hEF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1};
      vecs[4]  = '{8'h7E, 8'h00, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
      vecs[5]  = '{8'h60, 8'hFF, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
      vecs[6]  = '{8'h48, 8'h7F, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1};
      vecs[7]  = '{8'h49, 8'h7F, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1};
      vecs[8]  = '{8'h68, 8'hFF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1};
      vecs[9]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1};
      vecs[10] = '{8'h41, 8'hFE, 1'b1, 1'b0, 4'hE, 1'b1, 1'b0};
      vecs[11] = '{8'h61, 8'hFF, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
      vecs[12] = '{8'h24, 8'hFF, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1};

      #12;
      check_reset_values("reset");
      @(negedge clk);
      reset_n = 1'b1;
      no_pulses("idle after reset", 3);

      // Latency: status on the accepting edge, LED one edge later.
      send(8'h43);
      check("0x43 cat8", cat8, 8'hFB);
      check("0x43 ack", ack8, 1'b1);
      check("0x43 led early", led8, 8'h00);
      @(posedge clk);
      #1;
      check("0x43 led8", led8, 8'h04);
      check("0x43 ack drops", ack8, 1'b0);
      send(8'h63);
      check("0x63 cat8", cat8, 8'hFF);
      check("0x63 ack", ack8, 1'b1);
      @(posedge clk);
      #1;
      check("0x63 led8", led8, 8'h00);

      foreach (vecs[k]) begin
         send(vecs[k].b);
         check($sformatf("vec%0d cat8", k), cat8, vecs[k].cat8);
         check($sformatf("vec%0d ack/err8", k), {ack8, err8}, {vecs[k].ack8, vecs[k].err8});
         check($sformatf("vec%0d cat4", k), cat4, vecs[k].cat4);
         check($sformatf("vec%0d ack/err4", k), {ack4, err4}, {vecs[k].ack4, vecs[k].err4});
      end

      // Duty / PWM overlay.
      overlay    = 8'hFF;
      overlay_en = 1'b1;
      send(8'h23);
      check("0x23 no pulse", {ack8, err8}, 2'b00);
      send(8'h40);
      check("duty 0x40", duty8, 8'h40);
      check("duty ack", {ack8, err8}, 2'b10);
      repeat (3) @(posedge clk);
      count_full(256, n8, n4);
      check("pwm 0x40 led8 on", n8, 64);
      check("pwm 0x40 led4 on", n4, 64);
      send(8'h23);
      send(8'hFF);
      check("duty 0xFF", duty8, 8'hFF);
      repeat (3) @(posedge clk);
      count_full(256, n8, n4);
      check("pwm 0xFF on", n8, 256);
      send(8'h23);
      send(8'h00);
      check("duty 0x00", duty8, 8'h00);
      repeat (3) @(posedge clk);
      count_full(256, n8, n4);
      check("pwm 0x00 on", n8, 0);
      check("pwm 0x00 led", led8, 8'h00);
      overlay_en = 1'b0;

      // Operand timeout.
      send(8'h23);
      found = 0;
      for (int i = 1; i <= 200 && found == 0; i++) begin
         @(posedge clk);
         #1;
         if (ack8) found = -1;
         else if (err8) found = i;
      end
      check("timeout cycle", found, 100);
      check("timeout duty", duty8, 8'h00);
      @(posedge clk);
      #1;
      check("timeout err drops", err8, 1'b0);
      send(8'h23);
      send(8'h41);
      check("operand 0x41 duty", duty8, 8'h41);
      check("operand 0x41 cat", cat8, 8'hFF);
      check("operand 0x41 ack", {ack8, err8}, 2'b10);
      send(8'h7E);
      check("back in idle", cat8, 8'h00);
      send(8'h60);

      // Blink of channel 0.
      send(8'h41);
      send(8'h21);
      check("blink ack", ack8, 1'b1);
      @(posedge clk);
      #1;
      prev    = led8[0];
      last_t  = -1;
      ntog    = 0;
      bad_gap = 0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (led8[0] != prev[0]) begin
            if (last_t >= 0 && c - last_t != 10) bad_gap++;
            last_t = c;
            ntog++;
            prev = led8[0];
         end
      end
      check("blink gaps", bad_gap, 0);
      check("blink toggles", (ntog >= 5) ? 1 : 0, 1);
      check("blink other leds", led8[7:1], 7'h00);

      // Asynchronous reset mid-blink.
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_values("reset mid-blink");
      @(negedge clk);
      reset_n = 1'b1;
      no_pulses("after blink reset", 20);
      check("blink off after reset", led8, 8'h00);

      // Asynchronous reset while waiting for an operand.
      send(8'h23);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_values("reset mid-wait");
      @(negedge clk);
      reset_n = 1'b1;
      no_pulses("after wait reset", 150);
      check("duty after wait reset", duty8, 8'h80);
      send(8'h21);
      check("idle after wait reset", {ack8, err8}, 2'b10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cat_led_ctrl.md
CAT_LED_CTRL -- requirements
Module: cat_led_ctrl

Interface
REQ-001 Parameter CHANNELS, default 8: number of LED/cat channels; legal range 1..26.
REQ-002 Parameter PWM_BITS, default 8: PWM counter and duty width; legal range 2..16.
REQ-003 Parameter DEFAULT_DUTY, default 2**(PWM_BITS-1): duty loaded at reset.
REQ-004 Parameter TIMEOUT_CYCLES, default 1_000_000: maximum wait for a duty operand byte.
REQ-005 Parameter BLINK_DIV, default 50_000_000: cycles per blink half-period.
REQ-006 Ports:
- clk  in  1: single clock; all logic is in this domain.
- reset_n  in  1: asynchronous, active-low reset.
- rx_data  in  8: received UART byte.
- rx_valid  in  1: one-cycle strobe; rx_data is valid while high.
- overlay  in  CHANNELS: external pattern, such as the challenge LED output.
- overlay_en  in  1: enables the dimmed overlay.
- led  out  CHANNELS: registered LED drive.
- cat_status  out  CHANNELS: per-channel state; 1 = cat up, 0 = cat shot.
- duty  out  PWM_BITS: current global duty.
- cmd_ack  out  1: one-cycle pulse when a command completes.
- cmd_err  out  1: one-cycle pulse when a command is rejected or times out.

Function
REQ-007 Each command byte is consumed only in the cycle where rx_valid=1.
REQ-008 In IDLE, a byte 0x41+i (i<CHANNELS) clears cat_status[i] on the next edge and pulses cmd_ack.
REQ-009 In IDLE, a byte 0x61+i (i<CHANNELS) sets cat_status[i] on the next edge and pulses cmd_ack.
REQ-010 In IDLE, byte 0x60 sets all cat_status bits to 1 and byte 0x7E clears all bits to 0; each pulses cmd_ack.
REQ-011 In IDLE, byte 0x21 toggles blink_en and pulses cmd_ack.
REQ-012 In IDLE, byte 0x23 moves the FSM to WAIT_DUTY, clears the timeout counter, and pulses neither ack nor err.
REQ-013 In WAIT_DUTY, any valid byte is the operand, including command codes:
- duty <= byte[PWM_BITS-1:0] if PWM_BITS<=8; otherwise duty <= {byte, zeros}.
- cmd_ack pulses and the FSM returns to IDLE.
REQ-014 In WAIT_DUTY, if TIMEOUT_CYCLES elapse with no valid byte, the FSM returns to IDLE, cmd_err pulses, and duty is unchanged.
REQ-015 In IDLE, any other byte, including 0x41+i or 0x61+i with i>=CHANNELS, pulses cmd_err and changes no state.
REQ-016 FSM states are exactly IDLE and WAIT_DUTY; cmd_ack and cmd_err never assert in the same cycle.
REQ-017 The PWM counter is PWM_BITS wide, free-running, and wraps from all-ones to 0.
REQ-018 pwm_on = (cnt < duty) OR (duty == all-ones); duty=0 gives pwm_on permanently 0.
REQ-019 The blink counter wraps at BLINK_DIV-1 and toggles blink_phase on wrap; it runs regardless of blink_en.
REQ-020 led[i] is registered from (overlay[i] & overlay_en & pwm_on) | (~cat_status[i] & (blink_en ? blink_phase : 1)).
REQ-021 Latency: command byte at edge n → cat_status updated at n+1 → led reflects the change at n+2.
REQ-022 The overlay input has 1-cycle latency to led; it is not synchronised internally, so the caller supplies synchronous signals.

Reset
REQ-023 While reset_n=0, the block is held asynchronously in this state:
- cat_status all ones, led all zeros, duty=DEFAULT_DUTY.
- blink_en=0, blink_phase=0.
- PWM counter, blink counter and timeout counter all 0.
- FSM in IDLE; cmd_ack=cmd_err=0.
REQ-024 Reset asserted mid-operation, including in WAIT_DUTY, discards any pending operand; no ack or err pulse follows reset release.
REQ-025 reset_n release is synchronised by the system top before this block; no internal reset synchroniser is required.

Structure
REQ-026 Package cat_led_pkg holds:
- command byte constants: CMD_CLR_BASE 0x41, CMD_SET_BASE 0x61, CMD_ALL_UP 0x60, CMD_ALL_DOWN 0x7E, CMD_BLINK 0x21, CMD_DUTY 0x23.
- the FSM state type: IDLE, WAIT_DUTY.
REQ-027 Sub-module pwm_gen, parametrised by PWM_BITS, contains the PWM counter and comparator and outputs pwm_on; everything else stays in cat_led_ctrl.

Verification
REQ-028 Default parameters; send 0x43 then 0x63 → cat_status 0xFB then 0xFF; led[2]=1 two cycles after 0x43; cmd_ack pulses twice.
REQ-029 Send 0x23 then 0x40 → duty=0x40; with overlay=0xFF and overlay_en=1, each led is high for exactly 64 of every 256 cycles. Send 0x23,0xFF → led constantly high. Send 0x23,0x00 → led constantly low.
REQ-030 Send 0x23 and no operand, with TIMEOUT_CYCLES=100 → cmd_err pulses at cycle 100, FSM returns to IDLE, duty unchanged. Send 0x23 then 0x41 → duty=0x41 and cat_status unchanged.
REQ-031 CHANNELS=4; send 0x45 and 0x66 → cmd_err each time; cat_status stays 0xF. Send 0x7E → 0x0. Send 0x60 → 0xF.
REQ-032 Send 0x41, then 0x21 with BLINK_DIV=10 → led[0] toggles every 10 cycles. Assert reset_n=0 mid-blink and mid-WAIT_DUTY → all outputs take REQ-023 values immediately, with no pulse after release.
